// File: rtl/reg_bank.sv
// reg_bank: general registers on a shared data bus, paired into counters.
// Define REG_BANK_WRAP_EN to build the registered pair wrap-around pulse.
module reg_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int SEL_WIDTH  = $clog2(NUM_REGS),
  parameter int NUM_PAIRS  = NUM_REGS / 2,
  parameter int PSEL_WIDTH = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1,
  parameter int ADDR_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  WE,
  input  logic                  OE,
  input  logic [SEL_WIDTH-1:0]  sel,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  OE_A,
  input  logic                  INC,
  input  logic                  DEC,
  input  logic [PSEL_WIDTH-1:0] psel,
  output wire  [ADDR_WIDTH-1:0] address,
  output logic                  wrap
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_next [NUM_REGS];

  logic [SEL_WIDTH-1:0]  w_lo_idx;
  logic [SEL_WIDTH-1:0]  w_hi_idx;
  logic [ADDR_WIDTH-1:0] w_pair;
  logic [ADDR_WIDTH-1:0] w_pair_nxt;
  logic                  w_wr;
  logic                  w_inc;
  logic                  w_dec;
  logic                  w_same;
  logic                  w_cnt;

  assign w_lo_idx = SEL_WIDTH'({psel, 1'b0});
  assign w_hi_idx = SEL_WIDTH'({psel, 1'b1});
  assign w_pair   = {r_regs[w_hi_idx], r_regs[w_lo_idx]};

  assign w_wr  = CS & WE;
  assign w_inc = CS & INC & ~DEC;
  assign w_dec = CS & DEC & ~INC;

  // A write into the counted pair drops the count entirely.
  assign w_same = ((sel | SEL_WIDTH'(1)) == w_hi_idx);
  assign w_cnt  = (w_inc | w_dec) & ~(w_wr & w_same);

  assign w_pair_nxt = w_inc ? w_pair + ADDR_WIDTH'(1)
                            : w_pair - ADDR_WIDTH'(1);

  // Bank drives nothing while in reset; WE keeps it off its own input.
  assign data    = (reset & CS & OE & ~WE) ? r_regs[sel] : 'z;
  assign address = (reset & CS & OE_A) ? w_pair : 'z;

  // Next-state of the bank: count first, then the write on top.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_next[i] = r_regs[i];
    end
    if (w_cnt) begin
      w_next[w_lo_idx] = w_pair_nxt[DATA_WIDTH-1:0];
      w_next[w_hi_idx] = w_pair_nxt[ADDR_WIDTH-1:DATA_WIDTH];
    end
    if (w_wr) begin
      w_next[sel] = data;
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= w_next[i];
      end
    end
  end

`ifdef REG_BANK_WRAP_EN
  logic r_wrap;
  logic w_wrap_nxt;

  assign w_wrap_nxt = w_cnt & (w_inc ? (&w_pair) : ~(|w_pair));

  // One-cycle pulse on the edge where a count rolls over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_nxt;
    end
  end

  assign wrap = r_wrap;
`else
  assign wrap = 1'b0;
`endif

endmodule
